// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a combinational-read FIFO port into a valid/ready stream through a small skid buffer.
// Optional framing (packet_length / out_last) is enabled by defining FIFO_STREAM_READER_LAST_EN.
module fifo_stream_reader #(
  parameter int WIDTH        = 8,
  parameter int BUFFER_DEPTH = 2,
  parameter int LENGTH_WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  output logic                          fifo_read_enable,
  input  logic [WIDTH-1:0]              fifo_read_data,
  input  logic                          fifo_read_empty,
  output logic                          fifo_read_flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
`ifdef FIFO_STREAM_READER_LAST_EN
  input  logic [LENGTH_WIDTH-1:0]       packet_length,
  output logic                          out_last,
`endif
  output logic [$clog2(BUFFER_DEPTH):0] buffer_level
);

  localparam int CW = $clog2(BUFFER_DEPTH) + 1;
  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUFFER_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUFFER_DEPTH - 1);

  if (BUFFER_DEPTH < 1 || LENGTH_WIDTH < 1) begin : g_param_check
    $error("fifo_stream_reader: BUFFER_DEPTH and LENGTH_WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             fill;
  logic             pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Handshake: a word transfers on any rising edge where out_valid && out_ready; once raised,
  // out_valid and out_data hold until that transfer. The FIFO side pops on fifo_read_enable alone.
  // The read enable looks only at registered occupancy, so out_ready never reaches it combinationally.
  assign fifo_read_enable = !reset && !flush && !fifo_read_empty && (count < DEPTH_C);
  assign fifo_read_flush  = flush;
  assign fill             = fifo_read_enable;
  assign out_valid        = (count != '0);
  assign pop              = out_valid && out_ready;
  assign out_data         = mem[head];
  assign buffer_level     = count;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (fill) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      if (fill && !pop)      count <= count + CW'(1);
      else if (pop && !fill) count <= count - CW'(1);
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    if (fill) mem[tail] <= fifo_read_data;
  end

`ifdef FIFO_STREAM_READER_LAST_EN
  logic [LENGTH_WIDTH-1:0] beat;
  logic [LENGTH_WIDTH-1:0] last_beat;

  // A zero length behaves like a one-word packet.
  assign last_beat = (packet_length == '0) ? '0 : packet_length - LENGTH_WIDTH'(1);
  assign out_last  = out_valid && (beat == last_beat);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      beat <= '0;
    end else if (pop) begin
      beat <= out_last ? '0 : beat + LENGTH_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a FIFO model feeds the DUT, a scoreboard queue holds expected {last,data},
// and a negedge monitor pops and compares on every handshake.
module tb_fifo_stream_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             fifo_read_enable;
  logic [WIDTH-1:0] fifo_read_data;
  logic             fifo_read_empty;
  logic             fifo_read_flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       buffer_level;
`ifdef FIFO_STREAM_READER_LAST_EN
  logic [7:0]       packet_length;
  logic             out_last;
`endif

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH:0]   exp_q[$];
  logic             force_empty;
  int               rd_count = 0;
  int               n_tests = 0;
  int               n_fail = 0;

  fifo_stream_reader #(.WIDTH(WIDTH), .BUFFER_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .fifo_read_enable(fifo_read_enable),
    .fifo_read_data(fifo_read_data),
    .fifo_read_empty(fifo_read_empty),
    .fifo_read_flush(fifo_read_flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
`ifdef FIFO_STREAM_READER_LAST_EN
    .packet_length(packet_length),
    .out_last(out_last),
`endif
    .buffer_level(buffer_level)
  );

  // Clock and reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: combinational head word, pops on the edge where the DUT enabled a read.
  task automatic refresh();
    fifo_read_empty = (fifo_q.size() == 0) || force_empty;
    fifo_read_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  always @(posedge clock) begin
    logic ren_s;
    logic flush_s;
    ren_s   = fifo_read_enable;
    flush_s = fifo_read_flush;
    #1;
    if (ren_s && fifo_q.size() != 0) begin
      void'(fifo_q.pop_front());
      rd_count++;
    end
    if (flush_s) fifo_q.delete();
    refresh();
  end

  // Driver tasks
  task automatic slot();
    @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [WIDTH-1:0] d, input logic last);
    fifo_q.push_back(d);
    exp_q.push_back({last, d});
    refresh();
  endtask

  task automatic wait_drain(input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < budget) begin
      @(negedge clock);
      cyc++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    logic [WIDTH:0] e;
    if (!reset && !flush) begin
      if (fifo_read_enable)
        check("ren_legal", {31'd0, fifo_read_empty || (buffer_level == 2'(DEPTH))}, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {24'd0, out_data}, 32'hffff_ffff);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, e[WIDTH-1:0]});
`ifdef FIFO_STREAM_READER_LAST_EN
          check("out_last", {31'd0, out_last}, {31'd0, e[WIDTH]});
`endif
        end
      end
    end
  end

  initial begin
    int rd0;
    int cyc;
    reset = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    force_empty = 1'b0;
`ifdef FIFO_STREAM_READER_LAST_EN
    packet_length = 8'd1;
`endif
    refresh();
    repeat (3) slot();
    @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_level", buffer_level, 0);
    check("rst_ren", fifo_read_enable, 0);
    slot();
    reset = 1'b0;

    // 1: three words, full throughput, 1-cycle latency
    out_ready = 1'b1;
    load(8'h11, 1'b1); load(8'h22, 1'b1); load(8'h33, 1'b1);
    @(negedge clock);
    check("t1_ren_first", fifo_read_enable, 1);
    check("t1_valid_first", out_valid, 0);
    @(negedge clock);
    check("t1_w0", {out_valid, out_data}, {1'b1, 8'h11});
    @(negedge clock);
    check("t1_w1", {out_valid, out_data}, {1'b1, 8'h22});
    @(negedge clock);
    check("t1_w2", {out_valid, out_data}, {1'b1, 8'h33});
    check("t1_ren_empty", fifo_read_enable, 0);
    @(negedge clock);
    check("t1_idle", out_valid, 0);
    wait_drain(20);

    // 2: backpressure, exactly two reads then stall
    slot();
    out_ready = 1'b0;
    rd0 = rd_count;
    load(8'hA0, 1'b1); load(8'hA1, 1'b1); load(8'hA2, 1'b1); load(8'hA3, 1'b1); load(8'hA4, 1'b1);
    repeat (4) @(negedge clock);
    check("t2_reads", rd_count - rd0, 2);
    check("t2_level", buffer_level, 2);
    check("t2_ren", fifo_read_enable, 0);
    check("t2_head", {out_valid, out_data}, {1'b1, 8'hA0});
    repeat (3) @(negedge clock);
    check("t2_head_stable", {out_valid, out_data}, {1'b1, 8'hA0});
    slot();
    out_ready = 1'b1;
    wait_drain(50);

    // 3: random ready and FIFO empty over 1000 words
    for (int i = 0; i < 1000; i++) load(8'($urandom_range(0, 255)), 1'b1);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20000) begin
      slot();
      out_ready = 1'($urandom_range(0, 1));
      force_empty = 1'($urandom_range(0, 1));
      refresh();
      cyc++;
    end
    slot();
    out_ready = 1'b1;
    force_empty = 1'b0;
    refresh();
    wait_drain(50);

    // 4: flush with two words buffered
    slot();
    out_ready = 1'b0;
    load(8'hC0, 1'b1); load(8'hC1, 1'b1); load(8'hC2, 1'b1);
    repeat (3) @(negedge clock);
    check("t4_level_pre", buffer_level, 2);
    slot();
    flush = 1'b1;
    @(negedge clock);
    check("t4_flush_fwd", fifo_read_flush, 1);
    check("t4_ren", fifo_read_enable, 0);
    slot();
    flush = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("t4_valid", out_valid, 0);
    check("t4_level", buffer_level, 0);

    // 5: reset with two words buffered and FIFO non-empty
    slot();
    load(8'hD0, 1'b1); load(8'hD1, 1'b1); load(8'hD2, 1'b1); load(8'hD3, 1'b1);
    repeat (3) @(negedge clock);
    check("t5_level_pre", buffer_level, 2);
    slot();
    reset = 1'b1;
    @(negedge clock);
    check("t5_ren_rst0", fifo_read_enable, 0);
    @(negedge clock);
    check("t5_ren_rst1", fifo_read_enable, 0);
    check("t5_valid", out_valid, 0);
    check("t5_level", buffer_level, 0);
    slot();
    reset = 1'b0;
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    wait_drain(50);

`ifdef FIFO_STREAM_READER_LAST_EN
    // 6: framing with length 3, then length 0
    slot();
    packet_length = 8'd3;
    load(8'hE0, 1'b0); load(8'hE1, 1'b0); load(8'hE2, 1'b1);
    load(8'hE3, 1'b0); load(8'hE4, 1'b0); load(8'hE5, 1'b1); load(8'hE6, 1'b0);
    wait_drain(50);
    slot();
    flush = 1'b1;
    slot();
    flush = 1'b0;
    packet_length = 8'd0;
    load(8'hF0, 1'b1); load(8'hF1, 1'b1); load(8'hF2, 1'b1);
    wait_drain(50);
`endif

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
